// File: rtl/ps2_rx_word.sv
// PS/2 keyboard receiver that presents the last scancode, a new flag and an
// error flag as one M-bit word for the data memory's keyboard port.
// Both pins are synchronized. ps2_clk is also debounced before the
// falling-edge strobe drives the frame FSM.
module ps2_rx_word #(
    parameter int M           = 32,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    input  logic         ack,
    output logic [M-1:0] wdPS2,
    output logic         rx_valid
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_s;
    logic          data_s;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fe;

    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity;
    logic [TW-1:0] to_cnt;
    logic [7:0]    scancode;
    logic          new_flag;
    logic          err_flag;

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    // Two-flop synchronizers for both pins; they idle high like the bus itself.
    // NOTE: every clocked block uses non-blocking assignments so that all flops sample the pre-edge values of their inputs, as real hardware does.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Debounce ps2_clk. The level flips only after FILTER_LEN consecutive
    // samples that disagree with it. fe fires for one cycle on a filtered 1->0.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fe       <= 1'b0;
        end else begin
            fe <= 1'b0;
            if (clk_s == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s;
                filt_cnt <= '0;
                fe       <= filt_clk;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    // Frame FSM, mid-frame timeout, and the scancode/flag registers behind wdPS2.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            parity   <= 1'b0;
            to_cnt   <= '0;
            scancode <= '0;
            new_flag <= 1'b0;
            err_flag <= 1'b0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            // Flag sets further down override this clear when both happen together.
            if (ack) begin
                new_flag <= 1'b0;
                err_flag <= 1'b0;
            end

            if (state == IDLE || fe) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end

            if (state != IDLE && !fe && to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                // The PS/2 clock stalled mid-frame. Drop the partial frame without touching the flags.
                state <= IDLE;
            end else if (fe) begin
                case (state)
                    IDLE: begin
                        // A high data bit here is a spurious edge, not a start bit.
                        if (!data_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        parity <= data_s;
                        state  <= STOP;
                    end
                    default: begin
                        if (data_s && (^{shreg, parity})) begin
                            scancode <= shreg;
                            new_flag <= 1'b1;
                            rx_valid <= 1'b1;
                        end else begin
                            err_flag <= 1'b1;
                        end
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign wdPS2 = M'({err_flag, new_flag, scancode});

endmodule

// File: tb/tb_ps2_rx_word.sv
// Directed bench for ps2_rx_word. A 1 MHz system clock with 40-cycle PS/2
// half periods gives a 12.5 kHz keyboard clock.
module tb_ps2_rx_word;

    localparam int M           = 32;
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 50000;
    localparam int HALF        = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ps2_clk = 1'b1;
    logic          ps2_data = 1'b1;
    logic          ack = 1'b0;
    logic [M-1:0]  wdPS2;
    logic          rx_valid;

    int passed = 0;
    int total  = 0;

    // rx_valid monitor: counts pulses, and counts extra cycles of any pulse longer than one cycle.
    int pulses    = 0;
    int long_runs = 0;
    int run       = 0;

    ps2_rx_word #(.M(M), .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ack      (ack),
        .wdPS2    (wdPS2),
        .rx_valid (rx_valid)
    );

    always #500 clk = ~clk;

    always @(negedge clk) begin
        run       <= rx_valid ? run + 1 : 0;
        pulses    <= pulses + ((rx_valid && run == 0) ? 1 : 0);
        long_runs <= long_runs + ((rx_valid && run != 0) ? 1 : 0);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic par_flip, input logic stop);
        return {stop, (~^d) ^ par_flip, d, 1'b0};
    endfunction

    // Drive the first n bits of a frame, one falling edge per bit.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_clks(HALF);
            ps2_clk = 1'b0;
            wait_clks(HALF);
            ps2_clk = 1'b1;
        end
        wait_clks(HALF);
        ps2_data = 1'b1;
    endtask

    task automatic check_word(input string name, input logic [M-1:0] exp);
        total++;
        if (wdPS2 !== exp) $display("FAIL %s: wdPS2=%h expected %h", name, wdPS2, exp);
        else passed++;
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else passed++;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        wait_clks(1);
        ack = 1'b0;
        wait_clks(2);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        wait_clks(2);
    endtask

    task automatic test_reset();
        wait_clks(3);
        rst = 1'b0;
        wait_clks(2);
        check_word("reset_word", 32'h0000_0000);
        check_int("reset_rx_valid", int'(rx_valid), 0);
    endtask

    task automatic test_good_frame();
        int p0, l0;
        p0 = pulses;
        l0 = long_runs;
        send_bits(frame(8'h1C, 1'b0, 1'b1), 11);
        check_word("good_1c_word", 32'h0000_011C);
        check_int("good_1c_pulses", pulses - p0, 1);
        check_int("good_1c_pulse_width", long_runs - l0, 0);
    endtask

    task automatic test_error_frames();
        int p0;
        pulse_rst();
        p0 = pulses;
        send_bits(frame(8'h1C, 1'b1, 1'b1), 11);
        check_word("parity_err_word", 32'h0000_0200);
        check_int("parity_err_pulses", pulses - p0, 0);
        pulse_ack();
        check_word("parity_err_ack", 32'h0000_0000);
        p0 = pulses;
        send_bits(frame(8'h1C, 1'b0, 1'b0), 11);
        check_word("stop_err_word", 32'h0000_0200);
        check_int("stop_err_pulses", pulses - p0, 0);
        pulse_ack();
        check_word("stop_err_ack", 32'h0000_0000);
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pulses;
        send_bits(frame(8'h1C, 1'b0, 1'b1), 11);
        send_bits(frame(8'hF0, 1'b0, 1'b1), 11);
        check_word("b2b_word", 32'h0000_01F0);
        check_int("b2b_pulses", pulses - p0, 2);
        pulse_ack();
        check_word("b2b_ack", 32'h0000_00F0);
    endtask

    task automatic test_timeout();
        int p0;
        send_bits(frame(8'h29, 1'b0, 1'b1), 6);
        wait_clks(TIMEOUT_CYC + 10);
        check_word("timeout_no_change", 32'h0000_00F0);
        p0 = pulses;
        send_bits(frame(8'h29, 1'b0, 1'b1), 11);
        check_word("timeout_next_frame", 32'h0000_0129);
        check_int("timeout_next_pulses", pulses - p0, 1);
    endtask

    task automatic test_glitch_and_rst();
        pulse_ack();
        for (int g = 0; g < 4; g++) begin
            ps2_clk = 1'b0;
            wait_clks(3);
            ps2_clk = 1'b1;
            wait_clks(20);
        end
        check_word("glitch_no_change", 32'h0000_0029);
        send_bits(frame(8'h1C, 1'b0, 1'b1), 5);
        pulse_rst();
        check_word("rst_mid_word", 32'h0000_0000);
        check_int("rst_mid_rx_valid", int'(rx_valid), 0);
        send_bits(frame(8'h1C, 1'b0, 1'b1), 11);
        check_word("rst_next_frame", 32'h0000_011C);
    endtask

    task automatic test_set_wins();
        logic [10:0] fr;
        bit seen;
        pulse_ack();
        check_word("pre_setwins_ack", 32'h0000_001C);
        fr = frame(8'h5A, 1'b0, 1'b1);
        send_bits(fr, 10);
        ack = 1'b1;
        ps2_data = fr[10];
        wait_clks(HALF);
        ps2_clk = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4 * HALF && !seen; c++) begin
            wait_clks(1);
            if (rx_valid) seen = 1'b1;
        end
        ack = 1'b0;
        check_int("setwins_rx_seen", int'(seen), 1);
        wait_clks(HALF);
        ps2_clk = 1'b1;
        wait_clks(HALF);
        check_word("setwins_word", 32'h0000_015A);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_error_frames();
        test_back_to_back();
        test_timeout();
        test_glitch_and_rst();
        test_set_wins();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ps2_rx_word.md
Name: ps2_rx_word

Overview:
- Receives PS/2 keyboard frames from the ps2_clk/ps2_data pins and holds the last scancode as a 32-bit word.
- That word drives the data-memory input port dedicated to the keyboard. The memory rewrites the keyboard word (word address 62) every clock.
- Software polls that word, then acknowledges it through an address-decoded pulse.
- This block is the producing end of the memory's keyboard write port.

Parameters:
- M, 32, width of the output word; must be >= 10.
- FILTER_LEN, 8, number of consecutive equal synchronized samples required before the filtered ps2_clk level changes.
- TIMEOUT_CYC, 50000, clk cycles without a ps2_clk falling edge, mid-frame, that abort the frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin; asynchronous.
- ps2_data  in  1  raw PS/2 data pin; asynchronous.
- ack  in  1  one-cycle pulse; clears the new and error flags.
- wdPS2  out  M  status/data word fed to the memory keyboard port.
- rx_valid  out  1  one-cycle pulse on each good frame.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - wdPS2=0 and rx_valid=0.
  - FSM to IDLE; bit counter, shift register and timeout counter cleared.
  - Sync flops to 1 and filtered clock to 1.
  - rst applied mid-frame discards the partial frame.
- Input conditioning:
  - Both pins pass through a 2-FF synchronizer.
  - ps2_clk is then filtered: the filtered level changes only after FILTER_LEN consecutive identical synchronized samples.
  - A falling edge is filtered 1 -> 0 and is detected as a one-cycle strobe fe.
  - ps2_data is sampled (synchronized value) on the fe cycle.
- Frame format: start bit 0, 8 data bits LSB first, odd parity bit, stop bit 1. 11 falling edges in total.
- FSM (all transitions on fe unless stated):
  - IDLE: data=0 -> DATA with count=0; data=1 -> stay in IDLE (spurious edge).
  - DATA: shift the bit into shreg[7:0] from the MSB side (LSB-first frame). After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: check the frame, then -> IDLE.
    - Good frame: stop=1 and ^{shreg,parity}=1.
    - Parity bad or stop=0 -> error frame.
  - Timeout: in any state other than IDLE, the counter increments each cycle and resets on fe. When it reaches TIMEOUT_CYC -> IDLE, frame discarded, no flags change.
- Output word:
  - wdPS2[7:0] = last good scancode.
  - wdPS2[8] = new flag.
  - wdPS2[9] = error flag.
  - wdPS2[M-1:10] = 0.
- Good frame, on the cycle after the STOP fe:
  - wdPS2[7:0] gets the scancode and wdPS2[8] is set.
  - rx_valid pulses for exactly that cycle.
- Error frame:
  - wdPS2[9] is set; wdPS2[7:0] and wdPS2[8] are unchanged.
  - rx_valid is not pulsed.
- A new good frame while new=1 overwrites the scancode; new stays 1 (no overrun flag).
- ack clears wdPS2[8] and wdPS2[9]. The scancode is retained.
- ack on the same cycle as a flag set: the set wins.
- Latency: rx_valid/wdPS2 update exactly 1 cycle after the STOP-bit fe strobe. fe itself lags the pin by 2 + FILTER_LEN cycles.
- Throughput: back-to-back frames need no idle gap beyond the PS/2 protocol.

Test Plan:
- Reset, then drive 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at a 12.5 kHz PS/2 clock -> rx_valid is a single pulse and wdPS2=0x0000011C.
- Same frame with parity=1 -> wdPS2 bit 9 set, bits [8:0] unchanged (0x000 after reset), no rx_valid. Then ack -> wdPS2=0x00000000.
- 0x1C then 0xF0 with no ack in between -> wdPS2=0x000001F0. Then ack -> 0x000000F0.
- Stop the clock after 5 data bits for TIMEOUT_CYC+10 cycles, then send a full 0x29 frame -> wdPS2=0x00000129, no error flag.
- 3-cycle low glitches on ps2_clk in IDLE (FILTER_LEN=8) -> no fe, no state change. Assert rst mid-frame -> wdPS2=0 and the next full frame decodes correctly.
- Hold ack high on the cycle the good 0x5A frame completes -> wdPS2=0x0000015A (set wins).
